sram_bank_controller: RTL

//   Multi-bank controller for the iCE40UP SB_SPRAM256KA (16Kx16) primitives. Ganges 1, 2 or 4 SPRAMs into one address space.

---
 rtl/sram_bank_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sram_bank_controller.sv
// sram_bank_controller: gangs 1, 2 or 4 SPRAM banks (16Kx16 each) behind one buffered write and one buffered read request.
// Define SRAM_NIBBLE_MASK_EN to add the write_nibble_mask port (per-nibble write enable); otherwise all nibbles are written.
//
// state     | meaning
// IDLE      | nothing issued this cycle; picks pending write first, then pending read
// WRITE     | CS+WREN on the write bank; write buffer frees at the end of the cycle
// READ      | CS with WREN=0 on the read bank
// READ_WAIT | bank DATAOUT valid; returned on read_data with read_finished_strobe
module sram_bank_controller #(
  parameter int NUM_BANKS = 1,
  parameter int DATA_BUS_WIDTH = 16,
  localparam int SEL_W = $clog2(NUM_BANKS),
  localparam int ADDRESS_BUS_WIDTH = 14 + SEL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  input  logic [DATA_BUS_WIDTH-1:0]    write_data,
`ifdef SRAM_NIBBLE_MASK_EN
  input  logic [3:0]                   write_nibble_mask,
`endif
  input  logic                         write_strobe,
  output logic                         write_busy,
  input  logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_strobe,
  output logic                         read_busy,
  output logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic                         read_finished_strobe,
  output logic                         dropped_request
);

  localparam int BSEL_W = (SEL_W > 0) ? SEL_W : 1;

  if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : g_bad_banks
    $error("sram_bank_controller: NUM_BANKS must be 1, 2 or 4");
  end
  if (DATA_BUS_WIDTH != 16) begin : g_bad_width
    $error("sram_bank_controller: DATA_BUS_WIDTH must be 16");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;

  state_t state_q, state_d;

  logic [ADDRESS_BUS_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [15:0]                  wr_data_q;
  logic [3:0]                   wr_mask_q;
  logic                         write_busy_q, read_busy_q, dropped_q;
  logic [15:0]                  read_data_q;
  logic [BSEL_W-1:0]            wr_bank, rd_bank;

  logic [NUM_BANKS-1:0] bank_cs;
  logic                 bank_wren;
  logic [13:0]          bank_addr;
  logic [15:0]          bank_din;
  logic [3:0]           bank_mask;
  logic [15:0]          bank_dout [NUM_BANKS];
  logic [15:0]          rd_dout;

  // Fixed SPRAM power pins: always awake and powered.
  logic bank_standby, bank_sleep, bank_poweroff, bank_on;
  assign bank_standby  = 1'b0;
  assign bank_sleep    = 1'b0;
  assign bank_poweroff = 1'b1;
  assign bank_on       = bank_poweroff & ~bank_sleep & ~bank_standby;

  if (NUM_BANKS > 1) begin : g_sel
    assign wr_bank = wr_addr_q[ADDRESS_BUS_WIDTH-1:14];
    assign rd_bank = rd_addr_q[ADDRESS_BUS_WIDTH-1:14];
    assign rd_dout = bank_dout[rd_bank];
  end else begin : g_nosel
    assign wr_bank = '0;
    assign rd_bank = '0;
    assign rd_dout = bank_dout[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_addr_q    <= '0;
      write_busy_q <= 1'b0;
      read_busy_q  <= 1'b0;
      dropped_q    <= 1'b0;
      read_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (write_strobe) begin
        if (write_busy_q) begin
          dropped_q <= 1'b1;
        end else begin
          wr_addr_q    <= write_address;
          wr_data_q    <= write_data;
          write_busy_q <= 1'b1;
        end
      end
      if (read_strobe) begin
        if (read_busy_q) begin
          dropped_q <= 1'b1;
        end else begin
          rd_addr_q   <= read_address;
          read_busy_q <= 1'b1;
        end
      end
      if (state_q == WRITE) write_busy_q <= 1'b0;
      if (state_q == READ_WAIT) begin
        read_busy_q <= 1'b0;
        read_data_q <= rd_dout;
      end
    end
  end

`ifdef SRAM_NIBBLE_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_mask_q <= 4'hF;
    end else if (write_strobe && !write_busy_q) begin
      wr_mask_q <= write_nibble_mask;
    end
  end
`else
  assign wr_mask_q = 4'hF;
`endif

  // A read queued behind a write issues straight from WRITE so a same-cycle pair completes at t+4.
  always_comb begin
    state_d   = state_q;
    bank_cs   = '0;
    bank_wren = 1'b0;
    bank_addr = rd_addr_q[13:0];
    bank_din  = wr_data_q;
    bank_mask = wr_mask_q;
    case (state_q)
      IDLE: begin
        if (write_busy_q)     state_d = WRITE;
        else if (read_busy_q) state_d = READ;
      end
      WRITE: begin
        bank_cs[wr_bank] = 1'b1;
        bank_wren        = 1'b1;
        bank_addr        = wr_addr_q[13:0];
        state_d          = read_busy_q ? READ : IDLE;
      end
      READ: begin
        bank_cs[rd_bank] = 1'b1;
        state_d          = READ_WAIT;
      end
      READ_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [15:0] mem [16384];
    logic [15:0] dout_q;
    always_ff @(posedge clk) begin
      if (bank_cs[b] && bank_on) begin
        if (bank_wren) begin
          for (int n = 0; n < 4; n++) begin
            if (bank_mask[n]) mem[bank_addr][n*4 +: 4] <= bank_din[n*4 +: 4];
          end
        end else begin
          dout_q <= mem[bank_addr];
        end
      end
    end
    assign bank_dout[b] = dout_q;
  end

  assign write_busy           = write_busy_q;
  assign read_busy            = read_busy_q;
  assign dropped_request      = dropped_q;
  assign read_finished_strobe = (state_q == READ_WAIT);
  assign read_data            = (state_q == READ_WAIT) ? rd_dout : read_data_q;

endmodule
